branch_update_queue: RTL and testbench
======================================

// Module: branch_update_queue
// PURPOSE
//  Buffers committed conditional-branch outcomes and drains them, one per cycle, into the
//  gshare PHT write port that sits upstream of the branch predictor. Up to ENQ_WIDTH updates
//  arrive per cycle; the PHT accepts at most one write per cycle and may stall.
//  Computes each saturating 2-bit counter update and keeps queued counters coherent for
//  repeated PHT indices.
// PARAMETERS
//  DEPTH            8   queue entries (power of 2, >= ENQ_WIDTH)
//  ENQ_WIDTH        2   commit-side enqueue lanes
//  PHT_INDEX_WIDTH  10  PHT index bits (PC^GHR hash, computed by the producer)
//  CNT_WIDTH        2   PHT counter bits (saturating, max = 2**CNT_WIDTH-1)
// PORTS
//  clk          in   1                             clock
//  rst          in   1                             synchronous, active-high reset
//  enq_valid    in   ENQ_WIDTH                     lane carries a committed branch update
//  enq_index    in   ENQ_WIDTH x PHT_INDEX_WIDTH   PHT index used at prediction time
//  enq_taken    in   ENQ_WIDTH                     resolved direction
//  enq_cnt      in   ENQ_WIDTH x CNT_WIDTH         counter value read at prediction time
//  enq_ready    out  1                             queue can accept all lanes this cycle
//  pht_we       out  1                             write request to PHT (queue not empty)
//  pht_windex   out  PHT_INDEX_WIDTH               head entry index
//  pht_wdata    out  CNT_WIDTH                     updated counter for head entry
//  pht_wready   in   1                             PHT accepts write this cycle
//  count        out  clog2(DEPTH+1)                occupied entries
// BEHAVIOUR
//  - Reset: head=tail=count=0; all entries invalid; pht_we=0; enq_ready=1; reset wins over
//    every same-cycle enq/deq; asserting rst mid-operation discards all entries.
//  - enq_ready = (DEPTH - count) >= ENQ_WIDTH, from registered count only (same-cycle dequeue
//    not credited). Enqueue is all-or-nothing; enq_valid with enq_ready=0 is a protocol
//    violation (assertion), inputs are ignored.
//  - Valid lanes are compacted in lane order: lowest valid lane written at tail, next at
//    tail+1, ...; tail advances by popcount(enq_valid), wraps modulo DEPTH.
//  - Entry written on a clock edge is visible on pht_* the following cycle (1-cycle min latency).
//  - pht_we = (count != 0); pht_windex = head.index; pht_wdata = taken ? min(cnt+1, MAX)
//    : max(cnt-1, 0) using head.cnt; combinational from head entry.
//  - Pop when pht_we && pht_wready: head advances by 1 (wraps); pht_* held stable while
//    pht_wready=0.
//  - Coherence on pop with index X: every other valid entry with index X gets cnt :=
//    pht_wdata, including any entry enqueued in the same cycle.
//  - Same-cycle multi-lane enqueue with equal index: later lane stores the earlier lane's
//    enq_cnt (unmodified); the pop rule then chains the updates.
//  - Simultaneous enq and pop: count_next = count + popcount(enq_valid) - pop; full and empty
//    are exact (count==DEPTH / count==0), with no pointer-equality ambiguity.
// TESTING
//  1. Assert rst 2 cycles -> count=0, pht_we=0, enq_ready=1.
//  2. Enq lane0 idx=5 taken=1 cnt=1, pht_wready=1 -> next cycle pht_we=1, windex=5,
//     wdata=2; cycle after: count=0, pht_we=0.
//  3. Saturation: idx=3 cnt=3 taken=1 -> wdata=3; idx=4 cnt=0 taken=0 -> wdata=0.
//  4. Both lanes idx=7 cnt=1 taken=1, wready=1 -> writes 7:2 then 7:3 on consecutive cycles.
//  5. wready=0, enq 2 lanes/cycle x4 -> count 2,4,6,8; enq_ready=0 only at 8; wready=1
//     one cycle -> count=7, enq_ready=0; drain 8 writes in enqueue order across the wrap.
//  6. count=5, assert rst with enq_valid=2'b11 and wready=1 -> next cycle count=0, pht_we=0.

Source files
------------

// File: rtl/branch_update_queue.sv
// Circular queue of committed branch outcomes feeding the gshare PHT write port.
// Computes saturating counter updates at the head and keeps duplicate PHT indices coherent.
module branch_update_queue #(
    parameter int DEPTH           = 8,
    parameter int ENQ_WIDTH       = 2,
    parameter int PHT_INDEX_WIDTH = 10,
    parameter int CNT_WIDTH       = 2
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic [ENQ_WIDTH-1:0]                          i_enq_valid,
    input  logic [ENQ_WIDTH-1:0][PHT_INDEX_WIDTH-1:0]     i_enq_index,
    input  logic [ENQ_WIDTH-1:0]                          i_enq_taken,
    input  logic [ENQ_WIDTH-1:0][CNT_WIDTH-1:0]           i_enq_cnt,
    output logic                                          o_enq_ready,
    output logic                                          o_pht_we,
    output logic [PHT_INDEX_WIDTH-1:0]                    o_pht_windex,
    output logic [CNT_WIDTH-1:0]                          o_pht_wdata,
    input  logic                                          i_pht_wready,
    output logic [$clog2(DEPTH+1)-1:0]                    o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]        ENQ_C   = CW'(ENQ_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [PHT_INDEX_WIDTH-1:0] r_idx [DEPTH];
    logic                       r_tkn [DEPTH];
    logic [CNT_WIDTH-1:0]       r_cnt [DEPTH];
    logic [DEPTH-1:0]           r_valid;
    logic [PW-1:0]              r_head;
    logic [PW-1:0]              r_tail;
    logic [CW-1:0]              r_count;

    logic [PHT_INDEX_WIDTH-1:0] w_head_idx;
    logic [CNT_WIDTH-1:0]       w_head_cnt;
    logic                       w_head_tkn;
    logic                       w_pop;
    logic                       w_enq_fire;
    logic [CW-1:0]              w_enq_num;
    logic [PW-1:0]              w_slot     [ENQ_WIDTH];
    logic [CNT_WIDTH-1:0]       w_lane_cnt [ENQ_WIDTH];

    assign w_head_idx = r_idx[r_head];
    assign w_head_cnt = r_cnt[r_head];
    assign w_head_tkn = r_tkn[r_head];

    assign o_count      = r_count;
    assign o_pht_we     = (r_count != '0);
    assign o_pht_windex = w_head_idx;
    assign o_pht_wdata  = w_head_tkn ? ((w_head_cnt == CNT_MAX) ? CNT_MAX : w_head_cnt + CNT_WIDTH'(1))
                                     : ((w_head_cnt == '0) ? '0 : w_head_cnt - CNT_WIDTH'(1));

    // Readiness uses only the registered count; a same-cycle pop does not free a slot early.
    assign o_enq_ready = ((DEPTH_C - r_count) >= ENQ_C);
    assign w_pop       = o_pht_we & i_pht_wready;
    assign w_enq_fire  = o_enq_ready & (|i_enq_valid);

    // Compact valid lanes onto consecutive slots starting at the tail.
    always_comb begin
        logic [PW-1:0] v_off;
        v_off     = '0;
        w_enq_num = '0;
        for (int l = 0; l < ENQ_WIDTH; l++) begin
            w_slot[l] = r_tail + v_off;
            if (i_enq_valid[l]) begin
                v_off     = v_off + PW'(1);
                w_enq_num = w_enq_num + CW'(1);
            end
        end
    end

    // A later lane repeating an earlier lane's index inherits that lane's raw counter,
    // and any new entry matching the popping index picks up the freshly written value.
    always_comb begin
        for (int l = 0; l < ENQ_WIDTH; l++) begin
            w_lane_cnt[l] = i_enq_cnt[l];
            for (int j = 0; j < ENQ_WIDTH; j++) begin
                if (j < l && i_enq_valid[j] && i_enq_index[j] == i_enq_index[l]) begin
                    w_lane_cnt[l] = i_enq_cnt[j];
                end
            end
            if (w_pop && i_enq_index[l] == w_head_idx) begin
                w_lane_cnt[l] = o_pht_wdata;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_head          <= r_head + PW'(1);
                r_valid[r_head] <= 1'b0;
            end
            if (w_enq_fire) begin
                for (int l = 0; l < ENQ_WIDTH; l++) begin
                    if (i_enq_valid[l]) begin
                        r_valid[w_slot[l]] <= 1'b1;
                    end
                end
                r_tail <= r_tail + w_enq_num[PW-1:0];
            end
            r_count <= r_count + (w_enq_fire ? w_enq_num : '0) - CW'(w_pop);
        end
    end

    // Payload storage needs no reset: occupancy is tracked by r_valid and r_count.
    always_ff @(posedge i_clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (w_pop && r_valid[e] && PW'(e) != r_head && r_idx[e] == w_head_idx) begin
                r_cnt[e] <= o_pht_wdata;
            end
        end
        if (w_enq_fire) begin
            for (int l = 0; l < ENQ_WIDTH; l++) begin
                if (i_enq_valid[l]) begin
                    r_idx[w_slot[l]] <= i_enq_index[l];
                    r_tkn[w_slot[l]] <= i_enq_taken[l];
                    r_cnt[w_slot[l]] <= w_lane_cnt[l];
                end
            end
        end
    end

    a_enq_protocol: assert property (@(posedge i_clk) disable iff (i_rst)
                                     (|i_enq_valid) |-> o_enq_ready);

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: reset, counter saturation, lane compaction,
// index coherence, full/wrap behaviour and mid-operation reset.
module tb_branch_update_queue;

    localparam int IW = 10;

    logic                 i_clk;
    logic                 i_rst;
    logic [1:0]           i_enq_valid;
    logic [1:0][IW-1:0]   i_enq_index;
    logic [1:0]           i_enq_taken;
    logic [1:0][1:0]      i_enq_cnt;
    logic                 o_enq_ready;
    logic                 o_pht_we;
    logic [IW-1:0]        o_pht_windex;
    logic [1:0]           o_pht_wdata;
    logic                 i_pht_wready;
    logic [3:0]           o_count;

    int total = 0;
    int bad   = 0;

    branch_update_queue #(
        .DEPTH(8), .ENQ_WIDTH(2), .PHT_INDEX_WIDTH(IW), .CNT_WIDTH(2)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_enq_valid(i_enq_valid), .i_enq_index(i_enq_index),
        .i_enq_taken(i_enq_taken), .i_enq_cnt(i_enq_cnt),
        .o_enq_ready(o_enq_ready), .o_pht_we(o_pht_we),
        .o_pht_windex(o_pht_windex), .o_pht_wdata(o_pht_wdata),
        .i_pht_wready(i_pht_wready), .o_count(o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_lane(input int l, input int idx, input bit t, input int c);
        i_enq_index[l] = IW'(idx);
        i_enq_taken[l] = t;
        i_enq_cnt[l]   = 2'(c);
    endtask

    // Reference 2-bit saturating counter step.
    function automatic logic [1:0] next_cnt(input bit t, input int c);
        if (t) return (c >= 3) ? 2'd3 : 2'(c + 1);
        else   return (c <= 0) ? 2'd0 : 2'(c - 1);
    endfunction

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        total++; if (o_count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", o_count); end
        total++; if (o_pht_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got=%b want=0", o_pht_we); end
        total++; if (o_enq_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", o_enq_ready); end
        i_rst = 1'b0;
    endtask

    task automatic test_single();
        i_pht_wready = 1'b1;
        set_lane(0, 5, 1'b1, 1);
        i_enq_valid = 2'b01;
        tick();
        i_enq_valid = 2'b00;
        total++; if (o_pht_we !== 1'b1) begin bad++; $display("[TB] FAIL single_we got=%b want=1", o_pht_we); end
        total++; if (o_pht_windex !== IW'(5)) begin bad++; $display("[TB] FAIL single_idx got=%0d want=5", o_pht_windex); end
        total++; if (o_pht_wdata !== 2'd2) begin bad++; $display("[TB] FAIL single_data got=%0d want=2", o_pht_wdata); end
        tick();
        total++; if (o_count !== 4'd0) begin bad++; $display("[TB] FAIL single_drain_count got=%0d want=0", o_count); end
        total++; if (o_pht_we !== 1'b0) begin bad++; $display("[TB] FAIL single_drain_we got=%b want=0", o_pht_we); end
    endtask

    task automatic test_saturation();
        i_pht_wready = 1'b1;
        set_lane(0, 3, 1'b1, 3);
        set_lane(1, 4, 1'b0, 0);
        i_enq_valid = 2'b11;
        tick();
        i_enq_valid = 2'b00;
        total++; if (o_pht_windex !== IW'(3) || o_pht_wdata !== 2'd3) begin bad++;
            $display("[TB] FAIL sat_high got=%0d:%0d want=3:3", o_pht_windex, o_pht_wdata); end
        tick();
        total++; if (o_pht_windex !== IW'(4) || o_pht_wdata !== 2'd0) begin bad++;
            $display("[TB] FAIL sat_low got=%0d:%0d want=4:0", o_pht_windex, o_pht_wdata); end
        tick();
        // Only lane 1 valid: it must still land at the tail.
        set_lane(0, 11, 1'b1, 3);
        set_lane(1, 9, 1'b0, 2);
        i_enq_valid = 2'b10;
        tick();
        i_enq_valid = 2'b00;
        total++; if (o_pht_windex !== IW'(9) || o_pht_wdata !== 2'd1 || o_count !== 4'd1) begin bad++;
            $display("[TB] FAIL lane1_only got=%0d:%0d cnt=%0d want=9:1 cnt=1", o_pht_windex, o_pht_wdata, o_count); end
        tick();
    endtask

    task automatic test_same_index();
        i_pht_wready = 1'b1;
        set_lane(0, 7, 1'b1, 1);
        set_lane(1, 7, 1'b1, 0);
        i_enq_valid = 2'b11;
        tick();
        i_enq_valid = 2'b00;
        total++; if (o_pht_windex !== IW'(7) || o_pht_wdata !== 2'd2) begin bad++;
            $display("[TB] FAIL same_idx_first got=%0d:%0d want=7:2", o_pht_windex, o_pht_wdata); end
        tick();
        total++; if (o_pht_windex !== IW'(7) || o_pht_wdata !== 2'd3) begin bad++;
            $display("[TB] FAIL same_idx_second got=%0d:%0d want=7:3", o_pht_windex, o_pht_wdata); end
        tick();
        total++; if (o_count !== 4'd0) begin bad++; $display("[TB] FAIL same_idx_drain got=%0d want=0", o_count); end
    endtask

    task automatic test_coherence();
        i_pht_wready = 1'b0;
        set_lane(0, 40, 1'b1, 1);
        i_enq_valid = 2'b01;
        tick();
        set_lane(0, 40, 1'b1, 1);
        set_lane(1, 41, 1'b0, 2);
        i_enq_valid = 2'b11;
        tick();
        i_enq_valid = 2'b00;
        total++; if (o_count !== 4'd3 || o_pht_windex !== IW'(40) || o_pht_wdata !== 2'd2) begin bad++;
            $display("[TB] FAIL coh_head got=%0d:%0d cnt=%0d want=40:2 cnt=3", o_pht_windex, o_pht_wdata, o_count); end
        i_pht_wready = 1'b1;
        tick();
        total++; if (o_pht_windex !== IW'(40) || o_pht_wdata !== 2'd3) begin bad++;
            $display("[TB] FAIL coh_queued got=%0d:%0d want=40:3", o_pht_windex, o_pht_wdata); end
        tick();
        total++; if (o_pht_windex !== IW'(41) || o_pht_wdata !== 2'd1) begin bad++;
            $display("[TB] FAIL coh_other got=%0d:%0d want=41:1", o_pht_windex, o_pht_wdata); end
        tick();
        // Entry enqueued in the same cycle its index pops must take the new value.
        i_pht_wready = 1'b0;
        set_lane(0, 50, 1'b1, 0);
        i_enq_valid = 2'b01;
        tick();
        total++; if (o_pht_wdata !== 2'd1) begin bad++; $display("[TB] FAIL coh_setup got=%0d want=1", o_pht_wdata); end
        i_pht_wready = 1'b1;
        set_lane(0, 50, 1'b1, 0);
        i_enq_valid = 2'b01;
        tick();
        i_enq_valid = 2'b00;
        total++; if (o_count !== 4'd1 || o_pht_windex !== IW'(50) || o_pht_wdata !== 2'd2) begin bad++;
            $display("[TB] FAIL coh_same_cycle got=%0d:%0d cnt=%0d want=50:2 cnt=1", o_pht_windex, o_pht_wdata, o_count); end
        tick();
        total++; if (o_count !== 4'd0) begin bad++; $display("[TB] FAIL coh_drain got=%0d want=0", o_count); end
    endtask

    task automatic test_full_wrap();
        i_pht_wready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            set_lane(0, 16 + 2*s, bit'((2*s) % 2), (2*s) % 4);
            set_lane(1, 17 + 2*s, bit'((2*s+1) % 2), (2*s+1) % 4);
            i_enq_valid = 2'b11;
            tick();
            i_enq_valid = 2'b00;
            total++; if (o_count !== 4'(2*(s+1))) begin bad++;
                $display("[TB] FAIL fill_count step=%0d got=%0d want=%0d", s, o_count, 2*(s+1)); end
            total++; if (o_enq_ready !== (s < 3)) begin bad++;
                $display("[TB] FAIL fill_ready step=%0d got=%b want=%b", s, o_enq_ready, s < 3); end
            total++; if (o_pht_windex !== IW'(16)) begin bad++;
                $display("[TB] FAIL fill_hold step=%0d got=%0d want=16", s, o_pht_windex); end
        end
        i_pht_wready = 1'b1;
        total++; if (o_pht_wdata !== next_cnt(1'b0, 0)) begin bad++;
            $display("[TB] FAIL drain_k0 got=%0d want=%0d", o_pht_wdata, next_cnt(1'b0, 0)); end
        tick();
        total++; if (o_count !== 4'd7 || o_enq_ready !== 1'b0) begin bad++;
            $display("[TB] FAIL one_pop got cnt=%0d rdy=%b want cnt=7 rdy=0", o_count, o_enq_ready); end
        for (int k = 1; k < 8; k++) begin
            total++; if (o_pht_windex !== IW'(16 + k) || o_pht_wdata !== next_cnt(bit'(k % 2), k % 4)) begin bad++;
                $display("[TB] FAIL drain_k%0d got=%0d:%0d want=%0d:%0d", k, o_pht_windex, o_pht_wdata,
                         16 + k, next_cnt(bit'(k % 2), k % 4)); end
            tick();
        end
        total++; if (o_count !== 4'd0 || o_pht_we !== 1'b0) begin bad++;
            $display("[TB] FAIL wrap_empty got cnt=%0d we=%b want cnt=0 we=0", o_count, o_pht_we); end
    endtask

    task automatic test_reset_mid();
        i_pht_wready = 1'b0;
        set_lane(0, 70, 1'b1, 1); set_lane(1, 71, 1'b1, 1);
        i_enq_valid = 2'b11;
        tick();
        set_lane(0, 72, 1'b1, 1); set_lane(1, 73, 1'b1, 1);
        tick();
        set_lane(0, 74, 1'b1, 1);
        i_enq_valid = 2'b01;
        tick();
        total++; if (o_count !== 4'd5) begin bad++; $display("[TB] FAIL mid_fill got=%0d want=5", o_count); end
        i_rst = 1'b1;
        set_lane(0, 80, 1'b1, 1); set_lane(1, 81, 1'b1, 1);
        i_enq_valid  = 2'b11;
        i_pht_wready = 1'b1;
        tick();
        total++; if (o_count !== 4'd0 || o_pht_we !== 1'b0 || o_enq_ready !== 1'b1) begin bad++;
            $display("[TB] FAIL mid_reset got cnt=%0d we=%b rdy=%b want cnt=0 we=0 rdy=1", o_count, o_pht_we, o_enq_ready); end
        i_rst = 1'b0;
        set_lane(0, 90, 1'b0, 3);
        i_enq_valid = 2'b01;
        tick();
        i_enq_valid = 2'b00;
        total++; if (o_count !== 4'd1 || o_pht_windex !== IW'(90) || o_pht_wdata !== 2'd2) begin bad++;
            $display("[TB] FAIL post_reset got=%0d:%0d cnt=%0d want=90:2 cnt=1", o_pht_windex, o_pht_wdata, o_count); end
        tick();
    endtask

    initial begin
        i_rst        = 1'b1;
        i_enq_valid  = '0;
        i_enq_index  = '0;
        i_enq_taken  = '0;
        i_enq_cnt    = '0;
        i_pht_wready = 1'b0;
        test_reset();
        test_single();
        test_saturation();
        test_same_index();
        test_coherence();
        test_full_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
